// File: rtl/gcd_arb_pkg.sv
// Shared types and default sizing for the GCD request arbiter.
package gcd_arb_pkg;

    localparam int DefNBits      = 16;
    localparam int DefNReq       = 4;
    localparam int DefTimeoutCyc = 1024;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: the search starts one past the previous winner and
// wraps, so every active requester is reached within NReq grants.
module rr_arbiter #(
    parameter int NReq = 4,
    parameter int IdxW = 2
) (
    input  logic [NReq-1:0] req,
    input  logic [IdxW-1:0] last_grant,
    output logic [NReq-1:0] grant,
    output logic [IdxW-1:0] grant_idx,
    output logic            any_grant
);

    int              cand;
    logic [IdxW-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NReq; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NReq) begin
                cand = cand - NReq;
            end
            cand_idx = IdxW'(cand);
            if (!any_grant && req[cand_idx]) begin
                any_grant       = 1'b1;
                grant_idx       = cand_idx;
                grant[cand_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one GCD datapath among NReq requesters, one transaction at a time.
// Trivial operand pairs are answered directly without touching the datapath.
module gcd_arbiter
    import gcd_arb_pkg::*;
#(
    parameter int NBits      = DefNBits,
    parameter int NReq       = DefNReq,
    parameter int TimeoutCyc = DefTimeoutCyc
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NReq-1:0]       req_valid,
    output logic [NReq-1:0]       req_ready,
    input  logic [NReq*NBits-1:0] req_x,
    input  logic [NReq*NBits-1:0] req_y,
    output logic [NReq-1:0]       resp_valid,
    input  logic [NReq-1:0]       resp_ready,
    output logic [NBits-1:0]      resp_data,
    output logic                  resp_err,
    output logic [NBits-1:0]      gcd_xi,
    output logic [NBits-1:0]      gcd_yi,
    output logic                  gcd_start,
    input  logic                  gcd_rdy,
    input  logic [NBits-1:0]      gcd_xo
);

    localparam int IdxW = (NReq > 1) ? $clog2(NReq) : 1;
    localparam int CntW = $clog2(TimeoutCyc + 1);

    state_e            state_q, state_d;
    logic [IdxW-1:0]   last_grant_q, last_grant_d;
    logic [IdxW-1:0]   tag_q, tag_d;
    logic [NReq-1:0]   resp_valid_q, resp_valid_d;
    logic [NBits-1:0]  resp_data_q, resp_data_d;
    logic              resp_err_q, resp_err_d;
    logic [NBits-1:0]  gcd_xi_q, gcd_xi_d;
    logic [NBits-1:0]  gcd_yi_q, gcd_yi_d;
    logic              gcd_start_q, gcd_start_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              rdy_prev_q;

    logic [NReq-1:0]   grant_oh;
    logic [IdxW-1:0]   grant_idx;
    logic              any_grant;
    logic [NBits-1:0]  sel_x, sel_y;
    logic [NReq-1:0]   tag_oh;

    rr_arbiter #(
        .NReq (NReq),
        .IdxW (IdxW)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant_q),
        .grant      (grant_oh),
        .grant_idx  (grant_idx),
        .any_grant  (any_grant)
    );

    always_comb begin
        sel_x = '0;
        sel_y = '0;
        for (int i = 0; i < NReq; i++) begin
            if (grant_idx == IdxW'(i)) begin
                sel_x = req_x[i*NBits +: NBits];
                sel_y = req_y[i*NBits +: NBits];
            end
        end
    end

    always_comb begin
        tag_oh        = '0;
        tag_oh[tag_q] = 1'b1;
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        tag_d        = tag_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        gcd_xi_d     = gcd_xi_q;
        gcd_yi_d     = gcd_yi_q;
        cnt_d        = cnt_q;
        gcd_start_d  = 1'b0;
        req_ready    = '0;

        case (state_q)
            IDLE: begin
                if (any_grant) begin
                    // The accept strobe is combinational so it always coincides
                    // with the requester's own valid; it is held off during reset.
                    req_ready = rst ? grant_oh : '0;
                    tag_d     = grant_idx;
                    if (sel_x == '0 || sel_y == '0) begin
                        resp_data_d  = sel_x + sel_y;
                        resp_err_d   = 1'b0;
                        resp_valid_d = grant_oh;
                        state_d      = RESP;
                    end else if (sel_x == sel_y) begin
                        resp_data_d  = sel_x;
                        resp_err_d   = 1'b0;
                        resp_valid_d = grant_oh;
                        state_d      = RESP;
                    end else begin
                        gcd_xi_d    = sel_x;
                        gcd_yi_d    = sel_y;
                        gcd_start_d = 1'b1;
                        state_d     = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Only a fresh rising edge counts, so a rdy level left over from
                // an earlier job cannot complete this one.
                if (gcd_rdy && !rdy_prev_q) begin
                    resp_data_d  = gcd_xo;
                    resp_err_d   = 1'b0;
                    resp_valid_d = tag_oh;
                    gcd_xi_d     = '0;
                    gcd_yi_d     = '0;
                    state_d      = RESP;
                end else if (cnt_q == CntW'(TimeoutCyc - 1)) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = tag_oh;
                    gcd_xi_d     = '0;
                    gcd_yi_d     = '0;
                    state_d      = RESP;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            RESP: begin
                if (resp_ready[tag_q]) begin
                    resp_valid_d = '0;
                    last_grant_d = tag_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            last_grant_q <= IdxW'(NReq - 1);
            tag_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            gcd_xi_q     <= '0;
            gcd_yi_q     <= '0;
            gcd_start_q  <= 1'b0;
            cnt_q        <= '0;
            rdy_prev_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            tag_q        <= tag_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            gcd_xi_q     <= gcd_xi_d;
            gcd_yi_q     <= gcd_yi_d;
            gcd_start_q  <= gcd_start_d;
            cnt_q        <= cnt_d;
            rdy_prev_q   <= gcd_rdy;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign gcd_xi     = gcd_xi_q;
    assign gcd_yi     = gcd_yi_q;
    assign gcd_start  = gcd_start_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed plus randomized bench for gcd_arbiter against a plain-arithmetic
// reference (Euclid GCD, modular round-robin) and a delay-programmable datapath stub.
module tb_gcd_arbiter;

    localparam int NBits      = 16;
    localparam int NReq       = 4;
    localparam int TimeoutCyc = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NReq-1:0]       req_valid;
    logic [NReq-1:0]       req_ready;
    logic [NReq*NBits-1:0] req_x;
    logic [NReq*NBits-1:0] req_y;
    logic [NReq-1:0]       resp_valid;
    logic [NReq-1:0]       resp_ready;
    logic [NBits-1:0]      resp_data;
    logic                  resp_err;
    logic [NBits-1:0]      gcd_xi;
    logic [NBits-1:0]      gcd_yi;
    logic                  gcd_start;
    logic                  gcd_rdy = 1'b0;
    logic [NBits-1:0]      gcd_xo  = '0;

    int vectors     = 0;
    int miscompares = 0;
    int start_count = 0;
    int model_last  = NReq - 1;

    int               dp_delay = 0;
    bit               dp_stuck = 1'b0;
    logic             dp_busy  = 1'b0;
    int               dp_cnt   = 0;
    logic [NBits-1:0] dp_a     = '0;
    logic [NBits-1:0] dp_b     = '0;

    logic [NBits-1:0] op_x [NReq];
    logic [NBits-1:0] op_y [NReq];

    gcd_arbiter #(
        .NBits      (NBits),
        .NReq       (NReq),
        .TimeoutCyc (TimeoutCyc)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_x      (req_x),
        .req_y      (req_y),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .gcd_xi     (gcd_xi),
        .gcd_yi     (gcd_yi),
        .gcd_start  (gcd_start),
        .gcd_rdy    (gcd_rdy),
        .gcd_xo     (gcd_xo)
    );

    always #5 clk = ~clk;

    function automatic int ref_gcd(input int a, input int b);
        int t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int model_grant(input logic [NReq-1:0] mask, input int last);
        for (int k = 1; k <= NReq; k++) begin
            if (mask[(last + k) % NReq]) return (last + k) % NReq;
        end
        return -1;
    endfunction

    // Datapath stub: answers dp_delay cycles after the start pulse with a one-cycle rdy.
    always @(posedge clk) begin
        if (gcd_start) begin
            dp_busy <= 1'b1;
            dp_cnt  <= dp_delay;
            dp_a    <= gcd_xi;
            dp_b    <= gcd_yi;
            gcd_rdy <= 1'b0;
        end else if (dp_busy) begin
            if (dp_cnt == 0) begin
                dp_busy <= 1'b0;
                if (!dp_stuck) begin
                    gcd_rdy <= 1'b1;
                    gcd_xo  <= NBits'(ref_gcd(int'(dp_a), int'(dp_b)));
                end
            end else begin
                dp_cnt <= dp_cnt - 1;
            end
        end else begin
            gcd_rdy <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (gcd_start) start_count++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [NReq-1:0] mask);
        req_valid = mask;
        for (int i = 0; i < NReq; i++) begin
            req_x[i*NBits +: NBits] = op_x[i];
            req_y[i*NBits +: NBits] = op_y[i];
        end
    endtask

    task automatic run_txn(input logic [NReq-1:0] mask, input int dly,
                           input bit timeout_exp, output int obs_g);
        int               g;
        int               waits;
        int               starts0;
        int               exp_data;
        bit               bypass;
        logic [NReq-1:0]  oh;
        logic [NBits-1:0] x;
        logic [NBits-1:0] y;
        dp_delay   = dly;
        dp_stuck   = timeout_exp;
        g          = model_grant(mask, model_last);
        oh         = '0;
        oh[g]      = 1'b1;
        x          = op_x[g];
        y          = op_y[g];
        bypass     = (x == 0) || (y == 0) || (x == y);
        exp_data   = timeout_exp ? 0 : ref_gcd(int'(x), int'(y));
        resp_ready = '0;
        applyStimulus(mask);
        #1;
        for (int k = 0; k < 6 && req_ready == '0; k++) begin
            @(posedge clk); #1;
        end
        obs_g = -1;
        for (int i = 0; i < NReq; i++) begin
            if (req_ready[i]) obs_g = i;
        end
        checkOutput("grant", req_ready, oh);
        starts0 = start_count;
        @(posedge clk); #1;
        req_valid[g] = 1'b0;
        if (bypass) begin
            checkOutput("bypass_latency", resp_valid, oh);
            checkOutput("bypass_no_start", gcd_start, 0);
        end else begin
            checkOutput("start_pulse", gcd_start, 1);
            checkOutput("gcd_xi", gcd_xi, x);
            checkOutput("gcd_yi", gcd_yi, y);
            waits = 0;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (resp_valid != '0) break;
                waits++;
            end
            checkOutput("wait_cycles", waits, timeout_exp ? TimeoutCyc : dly + 2);
        end
        checkOutput("resp_valid", resp_valid, oh);
        checkOutput("resp_data", resp_data, exp_data);
        checkOutput("resp_err", resp_err, timeout_exp);
        resp_ready = ~oh;
        @(posedge clk); #1;
        checkOutput("foreign_ready_ignored", resp_valid, oh);
        checkOutput("resp_data_stable", resp_data, exp_data);
        checkOutput("no_accept_while_busy", req_ready, 0);
        resp_ready = oh;
        @(posedge clk); #1;
        resp_ready = '0;
        checkOutput("resp_cleared", resp_valid, 0);
        checkOutput("start_count", start_count - starts0, bypass ? 0 : 1);
        model_last = g;
    endtask

    initial begin
        int g;
        int stale;
        int exp_order [5];
        int r;
        int k;
        exp_order  = '{0, 1, 2, 3, 0};
        rst        = 1'b0;
        req_valid  = '0;
        req_x      = '0;
        req_y      = '0;
        resp_ready = '0;
        #12;
        checkOutput("rst_resp_valid", resp_valid, 0);
        checkOutput("rst_req_ready", req_ready, 0);
        checkOutput("rst_gcd_start", gcd_start, 0);
        checkOutput("rst_gcd_xi", gcd_xi, 0);
        checkOutput("rst_gcd_yi", gcd_yi, 0);
        checkOutput("rst_resp_data", resp_data, 0);
        checkOutput("rst_resp_err", resp_err, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_no_req", req_ready, 0);

        $display("[TB] all requesters active, round-robin wrap");
        op_x = '{16'd5, 16'd0, 16'd14, 16'd8};
        op_y = '{16'd5, 16'd6, 16'd21, 16'd12};
        for (int n = 0; n < 5; n++) begin
            run_txn(4'b1111, 1, 1'b0, g);
            checkOutput("wrap_order", g, exp_order[n]);
        end

        $display("[TB] directed datapath and bypass cases");
        op_x[0] = 16'd12; op_y[0] = 16'd18;
        run_txn(4'b0001, 3, 1'b0, g);
        op_x[1] = 16'd0;  op_y[1] = 16'd7;
        run_txn(4'b0010, 0, 1'b0, g);
        op_x[2] = 16'd9;  op_y[2] = 16'd9;
        run_txn(4'b0100, 0, 1'b0, g);

        $display("[TB] datapath timeout then normal service");
        op_x[3] = 16'd35; op_y[3] = 16'd21;
        run_txn(4'b1000, 0, 1'b1, g);
        op_x[0] = 16'd48; op_y[0] = 16'd36;
        run_txn(4'b0001, 2, 1'b0, g);

        $display("[TB] reset during WAIT");
        op_x[0]  = 16'd20; op_y[0] = 16'd30;
        dp_delay = 8;
        dp_stuck = 1'b0;
        applyStimulus(4'b0001);
        #1;
        for (int n = 0; n < 6 && req_ready == '0; n++) begin
            @(posedge clk); #1;
        end
        checkOutput("wait_rst_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        checkOutput("mid_rst_resp_valid", resp_valid, 0);
        checkOutput("mid_rst_gcd_start", gcd_start, 0);
        checkOutput("mid_rst_gcd_xi", gcd_xi, 0);
        checkOutput("mid_rst_gcd_yi", gcd_yi, 0);
        checkOutput("mid_rst_resp_data", resp_data, 0);
        checkOutput("mid_rst_resp_err", resp_err, 0);
        checkOutput("mid_rst_req_ready", req_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        model_last = NReq - 1;
        stale = 0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk); #1;
            if (resp_valid != '0 || gcd_start) stale++;
        end
        checkOutput("no_stale_resp", stale, 0);
        op_x[1] = 16'd27; op_y[1] = 16'd45;
        run_txn(4'b0011, 1, 1'b0, g);

        $display("[TB] randomized traffic");
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < NReq; i++) begin
                r = $urandom_range(0, 9);
                if (r == 0) begin
                    op_x[i] = '0;
                    op_y[i] = NBits'($urandom_range(0, 500));
                end else if (r == 1) begin
                    op_x[i] = NBits'($urandom_range(1, 500));
                    op_y[i] = op_x[i];
                end else begin
                    k       = $urandom_range(1, 50);
                    op_x[i] = NBits'(k * $urandom_range(1, 200));
                    op_y[i] = NBits'(k * $urandom_range(1, 200));
                end
            end
            run_txn(NReq'($urandom_range(1, 15)), $urandom_range(0, 6), 1'b0, g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
